fetch_prefetch_queue: RTL and testbench

Instruction prefetch buffer between the synchronous instruction ROM and the Fetch-Decode pipeline register. Owns the fetch PC and issues one ROM read per cycle while it has buffer credit. Queues returned instruction words with their PCs and presents the head entry to decode. Honours decode stalls from the hazard unit and flushes on a taken-branch redirect.

---
 rtl/fetch_prefetch_queue.sv | 117 +++++++++++
 tb/tb_fetch_prefetch_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch_queue
// Purpose  : Instruction prefetch buffer between a synchronous instruction
//            ROM and the Fetch-Decode pipeline register. Owns the fetch PC,
//            issues one ROM read per cycle while buffer credit remains,
//            queues returned words together with their PCs, and presents the
//            head entry to decode. Decode stalls hold the head entry.
//            A taken-branch redirect flushes the queue and restarts fetch.
// Ports    : clk            - clock, rising edge
//            reset          - asynchronous active-low reset
//            rom_address    - ROM read address (the fetch PC register)
//            rom_q          - ROM read data, one cycle after the address
//            stall          - decode not accepting the head this cycle
//            redirect_valid - taken branch from decode
//            redirect_pc    - branch target
//            instr_valid    - head entry present
//            instr          - head instruction word (0 when empty)
//            instr_pc       - PC of head instruction (0 when empty)
//            occupancy      - number of queued entries
// Revision : 1.0 - initial release
// ============================================================================
module fetch_prefetch_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [ADDR_W-1:0]          rom_address,
  input  logic [INSTR_W-1:0]         rom_q,
  input  logic                       stall,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       instr_valid,
  output logic [INSTR_W-1:0]         instr,
  output logic [ADDR_W-1:0]          instr_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH+1);

  // Fetch and queue control state
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_inflight_valid;
  logic [ADDR_W-1:0]  r_inflight_pc;

  // Entry storage; contents are only observed through a non-zero count,
  // so it needs no reset.
  logic [INSTR_W-1:0] r_mem_instr [DEPTH];
  logic [ADDR_W-1:0]  r_mem_pc    [DEPTH];

  logic [c_cnt_w-1:0] w_credit_used;
  logic               w_issue;
  logic               w_enq;
  logic               w_deq;
  logic               w_not_empty;

  // Credit counts the in-flight read as already occupying a slot, so a
  // returning word always has room. A dequeue in the same cycle is not
  // credited, which keeps the issue decision off the stall path.
  assign w_credit_used = r_count + c_cnt_w'(r_inflight_valid);
  assign w_issue       = !redirect_valid && (w_credit_used < c_cnt_w'(DEPTH));
  assign w_not_empty   = (r_count != '0);
  assign w_enq         = r_inflight_valid && !redirect_valid;
  assign w_deq         = w_not_empty && !stall && !redirect_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc       <= '0;
      r_rd_ptr         <= '0;
      r_wr_ptr         <= '0;
      r_count          <= '0;
      r_inflight_valid <= 1'b0;
      r_inflight_pc    <= '0;
    end else if (redirect_valid) begin
      // Flush: drop queued entries and the word returning this cycle,
      // then restart fetch at the branch target on the next cycle.
      r_count          <= '0;
      r_rd_ptr         <= r_wr_ptr;
      r_inflight_valid <= 1'b0;
      r_fetch_pc       <= redirect_pc;
    end else begin
      r_inflight_valid <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + ADDR_W'(1);
      end
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      r_count <= r_count + c_cnt_w'(w_enq) - c_cnt_w'(w_deq);
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_instr[r_wr_ptr] <= rom_q;
      r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
    end
  end

  assign rom_address = r_fetch_pc;
  assign instr_valid = w_not_empty;
  assign instr       = w_not_empty ? r_mem_instr[r_rd_ptr] : '0;
  assign instr_pc    = w_not_empty ? r_mem_pc[r_rd_ptr]    : '0;
  assign occupancy   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_prefetch_queue
// Purpose  : Self-checking bench for fetch_prefetch_queue. A synchronous ROM
//            model returns addr ^ 16'hA000. Stimulus loads the expected PC
//            stream into a scoreboard queue; a monitor pops and compares on
//            every dequeue. Directed checks cover reset, latency, fill/full,
//            redirect flush and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_queue;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;
  localparam int OCC_W   = $clog2(DEPTH+1);

  logic               clk = 1'b0;
  logic               reset;
  logic [ADDR_W-1:0]  rom_address;
  logic [INSTR_W-1:0] rom_q;
  logic               stall;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic [OCC_W-1:0]   occupancy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  logic [ADDR_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] mon_pc;

  fetch_prefetch_queue #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rom_address    (rom_address),
    .rom_q          (rom_q),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: registers the address, data one cycle later.
  always @(posedge clk) rom_q <= rom_address ^ 16'hA000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic load_expected(input logic [ADDR_W-1:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + ADDR_W'(i));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_address"}, 32'(rom_address), 32'h0);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
    check({tag, "_instr"},       32'(instr),       32'h0);
    check({tag, "_instr_pc"},    32'(instr_pc),    32'h0);
    check({tag, "_occupancy"},   32'(occupancy),   32'h0);
  endtask

  task automatic check_head(input string tag, input logic [ADDR_W-1:0] pc);
    check({tag, "_valid"}, 32'(instr_valid), 32'h1);
    check({tag, "_instr"}, 32'(instr),       32'(pc ^ 16'hA000));
    check({tag, "_pc"},    32'(instr_pc),    32'(pc));
  endtask

  // Restart from reset with the given stall level; reset released just
  // after a rising edge, so the next edge is the first fetch edge.
  task automatic restart(input logic stall_v);
    reset = 1'b0;
    stall = stall_v;
    redirect_valid = 1'b0;
    load_expected('0);
    tick();
    reset = 1'b1;
  endtask

  // Monitor: every accepted head must be the next expected PC in order.
  always @(negedge clk) begin
    if (reset) begin
      check("occupancy_bound", 32'(occupancy <= OCC_W'(DEPTH)), 32'h1);
      if (instr_valid && !stall && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL deq_unexpected: got pc %0h expected no dequeue", instr_pc);
        end else begin
          mon_pc = exp_q.pop_front();
          check("deq_pc",    32'(instr_pc), 32'(mon_pc));
          check("deq_instr", 32'(instr),    32'(mon_pc ^ 16'hA000));
          n_pops++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] pat;
    reset          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #2;
    check_all_zero("reset");

    // ---- Reset / fill streaming ----
    load_expected('0);
    tick();
    reset = 1'b1;
    tick();                         // edge 1: pc 0 issued
    sample();
    check("lat_edge1_valid", 32'(instr_valid), 32'h0);
    tick();                         // edge 2: pc 0 captured
    sample();
    check_head("lat_edge2", 16'h0000);
    check("lat_edge2_occ", 32'(occupancy), 32'h1);
    repeat (6) begin
      tick();
      sample();
      check("stream_occ",   32'(occupancy),   32'h1);
      check("stream_valid", 32'(instr_valid), 32'h1);
    end

    // ---- Redirect flush while streaming with valid head, stall=0 ----
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    tick();                         // redirect edge
    redirect_valid = 1'b0;
    load_expected(16'h0040);
    sample();
    check("redir_valid", 32'(instr_valid), 32'h0);
    check("redir_occ",   32'(occupancy),   32'h0);
    check("redir_addr",  32'(rom_address), 32'h0040);
    tick();
    sample();
    check("redir_e1_valid", 32'(instr_valid), 32'h0);
    tick();
    sample();
    check_head("redir_e2", 16'h0040);
    repeat (5) begin
      tick();
      sample();
    end

    // ---- Stall fill to full, then drain ----
    restart(1'b1);
    repeat (5) tick();
    sample();
    check("full_occ",  32'(occupancy),   32'h4);
    check("full_addr", 32'(rom_address), 32'h4);
    check_head("full_head", 16'h0000);
    repeat (3) tick();
    sample();
    check("full_hold_occ",  32'(occupancy),   32'h4);
    check("full_hold_addr", 32'(rom_address), 32'h4);
    check_head("full_hold_head", 16'h0000);
    tick();
    stall = 1'b0;
    repeat (12) tick();

    // ---- Redirect while stalled with a non-empty queue ----
    stall = 1'b1;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0080;
    tick();
    redirect_valid = 1'b0;
    load_expected(16'h0080);
    sample();
    check("redir_stall_occ",  32'(occupancy),   32'h0);
    check("redir_stall_addr", 32'(rom_address), 32'h0080);
    tick();
    tick();
    sample();
    check_head("redir_stall_e2", 16'h0080);
    tick();
    stall = 1'b0;

    // ---- Pointer wrap: irregular stall pattern ----
    pat = 24'b1011_0011_1000_1101_0110_0111;
    for (int i = 0; i < 24; i++) begin
      stall = pat[i];
      tick();
    end
    stall = 1'b0;
    repeat (6) tick();

    // ---- Asynchronous reset with three entries queued ----
    restart(1'b1);
    repeat (4) tick();
    sample();
    check("pre_reset_occ", 32'(occupancy), 32'h3);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    stall = 1'b0;
    load_expected('0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    sample();
    check_head("post_reset", 16'h0000);
    repeat (4) tick();

    check("dequeues_observed", 32'(n_pops >= 25), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
